// File: rtl/serial_cmp_ctrl.sv
// Bit-serial magnitude/equality controller: steps a shared 1-bit equality comparator over
// two latched WIDTH-bit operands MSB first and reports eq/gt/lt with a start/busy/done handshake.
module serial_cmp_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             cmp_a,
  output logic             cmp_b,
  input  logic             cmp_s
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COMPARE = 2'b01,
    ST_DONE    = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [IDX_W-1:0]   idx_r;
  logic               mism_r;
  logic               eq_r;
  logic               gt_r;
  logic               lt_r;
  logic               diff_s;
  logic               exit_s;

  // The comparator reports equality; a difference at the last bit or (with early exit) any bit ends the scan.
  assign diff_s = ~cmp_s;
  assign exit_s = ((EARLY_EXIT == 1'b1) && diff_s) || (idx_r == {IDX_W{1'b0}});

  assign eq = eq_r;
  assign gt = gt_r;
  assign lt = lt_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_COMPARE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_COMPARE: begin
        if (exit_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_COMPARE;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output decode; comparator inputs are forced low whenever no scan is in progress.
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    cmp_a = 1'b0;
    cmp_b = 1'b0;
    case (state_r)
      ST_COMPARE: begin
        busy  = 1'b1;
        cmp_a = a_r[idx_r];
        cmp_b = b_r[idx_r];
      end
      ST_DONE: done = 1'b1;
      default: begin
        busy  = 1'b0;
        done  = 1'b0;
      end
    endcase
  end

  // Operand latch, bit index and result registers; only the first (MSB-most) difference sets gt/lt.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r    <= {WIDTH{1'b0}};
      b_r    <= {WIDTH{1'b0}};
      idx_r  <= IDX_W'(WIDTH - 1);
      mism_r <= 1'b0;
      eq_r   <= 1'b0;
      gt_r   <= 1'b0;
      lt_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_r    <= a_in;
            b_r    <= b_in;
            idx_r  <= IDX_W'(WIDTH - 1);
            mism_r <= 1'b0;
            eq_r   <= 1'b0;
            gt_r   <= 1'b0;
            lt_r   <= 1'b0;
          end
        end
        ST_COMPARE: begin
          if (diff_s && !mism_r) begin
            gt_r   <= cmp_a;
            lt_r   <= ~cmp_a;
            mism_r <= 1'b1;
          end
          if (exit_s) begin
            eq_r <= ~mism_r & cmp_s;
          end else begin
            idx_r <= idx_r - IDX_W'(1);
          end
        end
        default: begin
          mism_r <= mism_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Scoreboard bench for serial_cmp_ctrl: one early-exit and one full-scan instance, each wired
// to a behavioural 1-bit equality comparator, checked against a word-level reference model.
module tb_serial_cmp_ctrl;

  typedef struct {
    int inst;
    int cyc;
    bit eq;
    bit gt;
    bit lt;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] start_v;
  logic [7:0] a_v [2];
  logic [7:0] b_v [2];
  logic [1:0] busy_v, done_v, eq_v, gt_v, lt_v, cmp_a_v, cmp_b_v, cmp_s_v;

  int   cyc;
  int   checks;
  int   errors;
  exp_t exp_q [$];

  assign cmp_s_v = ~(cmp_a_v ^ cmp_b_v);

  serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst(rst), .start(start_v[0]), .a_in(a_v[0]), .b_in(b_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .eq(eq_v[0]), .gt(gt_v[0]), .lt(lt_v[0]),
    .cmp_a(cmp_a_v[0]), .cmp_b(cmp_b_v[0]), .cmp_s(cmp_s_v[0])
  );

  serial_cmp_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst(rst), .start(start_v[1]), .a_in(a_v[1]), .b_in(b_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .eq(eq_v[1]), .gt(gt_v[1]), .lt(lt_v[1]),
    .cmp_a(cmp_a_v[1]), .cmp_b(cmp_b_v[1]), .cmp_s(cmp_s_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Bits examined: the whole word unless early exit stops at the first MSB-first difference.
  function automatic int exp_k(input logic [7:0] a, input logic [7:0] b, input bit ee);
    if (!ee || a == b) return 8;
    for (int p = 7; p >= 0; p--) begin
      if (a[p] != b[p]) return 8 - p;
    end
    return 8;
  endfunction

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!busy_v[i]) begin
        chk($sformatf("cmp_a_idle[%0d]", i), {31'd0, cmp_a_v[i]}, 32'd0);
        chk($sformatf("cmp_b_idle[%0d]", i), {31'd0, cmp_b_v[i]}, 32'd0);
      end
      if (done_v[i]) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("unexpected_done[%0d]", i), 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk($sformatf("done_inst[%0d]", i), i, e.inst);
          chk($sformatf("done_cycle[%0d]", i), cyc, e.cyc);
          chk($sformatf("eq[%0d]", i), {31'd0, eq_v[i]}, {31'd0, e.eq});
          chk($sformatf("gt[%0d]", i), {31'd0, gt_v[i]}, {31'd0, e.gt});
          chk($sformatf("lt[%0d]", i), {31'd0, lt_v[i]}, {31'd0, e.lt});
          chk($sformatf("busy_at_done[%0d]", i), {31'd0, busy_v[i]}, 32'd0);
        end
      end
    end
  end

  task automatic run_cmp(input int inst, input logic [7:0] a, input logic [7:0] b, input bit repulse);
    exp_t e;
    int   k;
    @(negedge clk);
    a_v[inst] = a;
    b_v[inst] = b;
    start_v[inst] = 1'b1;
    @(posedge clk);
    #1;
    k = exp_k(a, b, inst == 0);
    e.inst = inst;
    e.cyc  = cyc + k;
    e.eq   = (a == b);
    e.gt   = (a > b);
    e.lt   = (a < b);
    exp_q.push_back(e);
    @(negedge clk);
    start_v[inst] = 1'b0;
    a_v[inst] = 8'($urandom);
    b_v[inst] = 8'($urandom);
    if (repulse) begin
      repeat (2) @(negedge clk);
      a_v[inst] = ~a;
      b_v[inst] = b ^ 8'h81;
      start_v[inst] = 1'b1;
      @(negedge clk);
      start_v[inst] = 1'b0;
    end
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk($sformatf("done_timeout[%0d]", inst), 32'd1, 32'd0);
      exp_q.delete();
    end
    repeat (2) @(negedge clk);
    chk($sformatf("eq_held[%0d]", inst), {31'd0, eq_v[inst]}, {31'd0, e.eq});
    chk($sformatf("gt_held[%0d]", inst), {31'd0, gt_v[inst]}, {31'd0, e.gt});
    chk($sformatf("lt_held[%0d]", inst), {31'd0, lt_v[inst]}, {31'd0, e.lt});
    chk($sformatf("busy_idle[%0d]", inst), {31'd0, busy_v[inst]}, 32'd0);
  endtask

  task automatic reset_abort(input int inst);
    @(negedge clk);
    a_v[inst] = 8'h55;
    b_v[inst] = 8'h55;
    start_v[inst] = 1'b1;
    @(negedge clk);
    start_v[inst] = 1'b0;
    repeat (3) @(negedge clk);
    chk($sformatf("busy_before_abort[%0d]", inst), {31'd0, busy_v[inst]}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk($sformatf("abort_busy[%0d]", inst), {31'd0, busy_v[inst]}, 32'd0);
    chk($sformatf("abort_done[%0d]", inst), {31'd0, done_v[inst]}, 32'd0);
    chk($sformatf("abort_res[%0d]", inst), {29'd0, eq_v[inst], gt_v[inst], lt_v[inst]}, 32'd0);
    repeat (12) @(negedge clk);
    chk($sformatf("abort_stays_idle[%0d]", inst), {31'd0, busy_v[inst]}, 32'd0);
  endtask

  initial begin
    cyc     = 0;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    start_v = 2'b00;
    for (int i = 0; i < 2; i++) begin
      a_v[i] = 8'h00;
      b_v[i] = 8'h00;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_busy[%0d]", i), {31'd0, busy_v[i]}, 32'd0);
      chk($sformatf("rst_done[%0d]", i), {31'd0, done_v[i]}, 32'd0);
      chk($sformatf("rst_res[%0d]", i), {29'd0, eq_v[i], gt_v[i], lt_v[i]}, 32'd0);
      chk($sformatf("rst_cmp[%0d]", i), {30'd0, cmp_a_v[i], cmp_b_v[i]}, 32'd0);
    end
    rst = 1'b0;

    run_cmp(0, 8'hA5, 8'hA5, 1'b0);
    run_cmp(1, 8'hA5, 8'hA5, 1'b0);
    run_cmp(0, 8'h80, 8'h7F, 1'b0);
    run_cmp(0, 8'h12, 8'h13, 1'b0);
    run_cmp(1, 8'h80, 8'h7F, 1'b0);
    run_cmp(1, 8'h12, 8'h13, 1'b0);
    run_cmp(0, 8'h3C, 8'h3D, 1'b1);
    run_cmp(1, 8'hF0, 8'h0F, 1'b1);

    reset_abort(0);
    run_cmp(0, 8'h40, 8'h41, 1'b0);
    reset_abort(1);
    run_cmp(1, 8'h01, 8'h00, 1'b0);

    // rst and start together: reset must win
    @(negedge clk);
    rst = 1'b1;
    start_v[0] = 1'b1;
    a_v[0] = 8'h01;
    b_v[0] = 8'h02;
    @(negedge clk);
    rst = 1'b0;
    start_v[0] = 1'b0;
    chk("rst_beats_start", {31'd0, busy_v[0]}, 32'd0);
    repeat (12) @(negedge clk);

    for (int t = 0; t < 40; t++) begin
      logic [7:0] a, b;
      int         inst;
      bit         rep;
      inst = t % 2;
      a = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (8'h01 << $urandom_range(0, 7));
        default: b = 8'($urandom);
      endcase
      rep = (exp_k(a, b, inst == 0) >= 4) && ($urandom_range(0, 1) == 1);
      run_cmp(inst, a, b, rep);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
